// File: rtl/uart_tx_arbiter.sv
// Two-source byte arbiter feeding one UART transmitter: round-robin between packets,
// grant held for a whole packet, per-byte completion watchdog.
//   state  | meaning
//   IDLE   | choose a source; the grant and its ready pulse happen in this cycle
//   LAUNCH | one-cycle start pulse to the transmitter
//   WAIT   | wait for tx_done, with the timeout counter running
//   GAP    | one quiet cycle so the transmitter can re-arm
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  input  logic [7:0] s0_byte,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_byte,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       busy,
  output logic       owner,
  output logic       locked,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        owner_q, owner_d;
  logic        locked_q, locked_d;
  logic        last_q, last_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] cnt_q, cnt_d;

  logic        gnt_vld;
  logic        gnt_idx;

  // While a packet is open, only its owner can be granted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = owner_q;
    if (locked_q) begin
      gnt_vld = owner_q ? s1_valid : s0_valid;
    end else if (s0_valid && s1_valid) begin
      gnt_vld = 1'b1;
      gnt_idx = rr_q;
    end else if (s0_valid) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b0;
    end else if (s1_valid) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    locked_d  = locked_q;
    last_d    = last_q;
    tx_byte_d = tx_byte_q;
    cnt_d     = cnt_q;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    tx_dv     = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          s0_ready  = ~gnt_idx;
          s1_ready  = gnt_idx;
          owner_d   = gnt_idx;
          tx_byte_d = gnt_idx ? s1_byte : s0_byte;
          last_d    = gnt_idx ? s1_last : s0_last;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_dv   = 1'b1;
        cnt_d   = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (tx_done) begin
          state_d = GAP;
          if (last_q) begin
            locked_d = 1'b0;
            rr_d     = ~owner_q;
          end else begin
            locked_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          err      = 1'b1;
          locked_d = 1'b0;
          rr_d     = ~owner_q;
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      tx_dv    = 1'b0;
      err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      locked_q  <= 1'b0;
      last_q    <= 1'b0;
      tx_byte_q <= 8'h00;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      last_q    <= last_d;
      tx_byte_q <= tx_byte_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tx_byte = tx_byte_q;
  assign owner   = owner_q;
  assign locked  = locked_q;
  assign busy    = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed sources, a scripted transmitter, a per-cycle
// transaction-level reference, and directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
  localparam int T = 8;

  logic       clk, rst;
  logic       s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic [7:0] s0_byte, s1_byte, tx_byte;
  logic       tx_dv, tx_done, busy, owner, locked, err;

  int n_cmp = 0;
  int n_mis = 0;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_byte(s0_byte), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_byte(s1_byte), .s1_last(s1_last), .s1_ready(s1_ready),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
    .busy(busy), .owner(owner), .locked(locked), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Source queues hold {last, byte}; head is offered until accepted.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit acc0, acc1;

  initial begin
    s0_valid = 1'b0; s0_byte = 8'h00; s0_last = 1'b0;
    s1_valid = 1'b0; s1_byte = 8'h00; s1_last = 1'b0;
    forever begin
      @(negedge clk);
      acc0 = s0_ready && s0_valid;
      acc1 = s1_ready && s1_valid;
      @(posedge clk);
      #1;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      s0_valid = (q0.size() > 0);
      {s0_last, s0_byte} = (q0.size() > 0) ? q0[0] : 9'h000;
      s1_valid = (q1.size() > 0);
      {s1_last, s1_byte} = (q1.size() > 0) ? q1[0] : 9'h000;
    end
  end

  // Transmitter: tx_done in WAIT cycle number done_delay (0-based); -1 means never.
  int done_delay = -1;
  bit inject_done = 1'b0;
  int resp_cd = -1;
  bit resp_launch;

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      resp_launch = tx_dv;
      @(posedge clk);
      #1;
      if (resp_launch && done_delay >= 0) resp_cd = done_delay;
      if (inject_done) begin
        tx_done = 1'b1;
        inject_done = 1'b0;
      end else if (resp_cd == 0) begin
        tx_done = 1'b1;
        resp_cd = -1;
      end else begin
        tx_done = 1'b0;
        if (resp_cd > 0) resp_cd--;
      end
    end
  end

  // Reference: m_age = -1 idle, -2 gap, otherwise cycles since the byte was accepted.
  int         m_age = -1;
  bit         m_rr = 1'b0, m_owner = 1'b0, m_locked = 1'b0, m_last = 1'b0;
  logic [7:0] m_txb = 8'h00;
  int         cyc = 0;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  int         last_dv_cyc = 0, last_gnt_cyc = 0, last_err_cyc = 0, n_err = 0, n_dv = 0;
  int         g;
  bit         e_r0, e_r1, e_dv, e_err, e_busy;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      g = -1;
      if (!rst && m_age == -1) begin
        if (m_locked) begin
          if (m_owner ? s1_valid : s0_valid) g = m_owner ? 1 : 0;
        end else if (s0_valid && s1_valid) g = m_rr ? 1 : 0;
        else if (s0_valid) g = 0;
        else if (s1_valid) g = 1;
      end
      e_r0   = (g == 0);
      e_r1   = (g == 1);
      e_dv   = !rst && (m_age == 1);
      e_busy = !rst && (m_age != -1);
      e_err  = !rst && (m_age >= 2) && !tx_done && ((m_age - 2) == T - 1);
      check("s0_ready", 16'(s0_ready), 16'(e_r0));
      check("s1_ready", 16'(s1_ready), 16'(e_r1));
      check("tx_dv",    16'(tx_dv),    16'(e_dv));
      check("busy",     16'(busy),     16'(e_busy));
      check("err",      16'(err),      16'(e_err));
      check("owner",    16'(owner),    16'(m_owner));
      check("locked",   16'(locked),   16'(m_locked));
      check("tx_byte",  16'(tx_byte),  16'(m_txb));
      if (tx_dv) begin
        log_q.push_back(tx_byte);
        last_dv_cyc = cyc;
        n_dv++;
      end
      if (err) begin
        last_err_cyc = cyc;
        n_err++;
      end
      if (s0_ready || s1_ready) last_gnt_cyc = cyc;
      if (rst) begin
        m_age = -1; m_rr = 1'b0; m_owner = 1'b0; m_locked = 1'b0; m_last = 1'b0; m_txb = 8'h00;
      end else if (m_age == -1) begin
        if (g >= 0) begin
          m_owner = (g == 1);
          m_txb   = (g == 1) ? s1_byte : s0_byte;
          m_last  = (g == 1) ? s1_last : s0_last;
          m_age   = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age >= 2) begin
        if (tx_done) begin
          if (m_last) begin
            m_locked = 1'b0;
            m_rr = !m_owner;
          end else m_locked = 1'b1;
          m_age = -2;
        end else if (m_age - 2 == T - 1) begin
          m_locked = 1'b0;
          m_rr = !m_owner;
          m_age = -2;
        end else m_age++;
      end else begin
        m_age = -1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int i;
    i = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !busy) && i < budget) begin
      tick(1);
      i++;
    end
    if (i >= budget) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s: actual=no idle within %0d cycles required=idle", nm, budget);
    end
    tick(2);
  endtask

  task automatic wait_dv(input string nm, input int budget);
    int i;
    i = 0;
    while (!tx_dv && i < budget) begin
      tick(1);
      i++;
    end
    if (i >= budget) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s: actual=no tx_dv within %0d cycles required=tx_dv", nm, budget);
    end
  endtask

  task automatic check_order(input string nm);
    check({nm, "_len"}, 16'(log_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_%0d", nm, i), 16'(log_q[i]), 16'(exp_q[i]));
    log_q.delete();
  endtask

  int err_before, dv_before;

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_busy",    16'(busy),    16'd0);
    check("rst_tx_byte", 16'(tx_byte), 16'h00);
    check("rst_owner",   16'(owner),   16'd0);
    check("rst_locked",  16'(locked),  16'd0);

    // single byte from source 0
    done_delay = 3;
    q0.push_back({1'b1, 8'h41});
    wait_idle("single", 60);
    exp_q = '{8'h41};
    check_order("single_order");
    check("single_latency", 16'(last_dv_cyc - last_gnt_cyc), 16'd1);

    // rr now points to source 1
    q0.push_back({1'b1, 8'hA0});
    q1.push_back({1'b1, 8'hB0});
    wait_idle("rr_after_s0", 80);
    exp_q = '{8'hB0, 8'hA0};
    check_order("rr_order");

    // contention from reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    done_delay = 1;
    q0.push_back({1'b1, 8'h61}); q0.push_back({1'b1, 8'h61});
    q1.push_back({1'b1, 8'h62}); q1.push_back({1'b1, 8'h62});
    wait_idle("contend", 120);
    exp_q = '{8'h61, 8'h62, 8'h61, 8'h62};
    check_order("contend_order");

    // three-byte packet from s0 holds the grant while s1 waits
    q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
    q1.push_back({1'b1, 8'hB1});
    wait_idle("lock", 150);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'hB1};
    check_order("lock_order");

    // locked owner goes quiet: s1 must wait indefinitely
    q0.push_back({1'b0, 8'h11});
    q1.push_back({1'b1, 8'h22});
    tick(25);
    exp_q = '{8'h11};
    check_order("stall_order");
    check("stall_locked", 16'(locked), 16'd1);
    check("stall_busy",   16'(busy),   16'd0);
    q0.push_back({1'b1, 8'h12});
    wait_idle("stall_resume", 80);
    exp_q = '{8'h12, 8'h22};
    check_order("resume_order");

    // timeout with no tx_done
    done_delay = -1;
    err_before = n_err;
    q0.push_back({1'b0, 8'h55});
    wait_idle("timeout", 60);
    exp_q = '{8'h55};
    check_order("timeout_order");
    check("timeout_err_count", 16'(n_err - err_before), 16'd1);
    check("timeout_err_cycle", 16'(last_err_cyc - last_dv_cyc), 16'd8);
    check("timeout_locked",    16'(locked), 16'd0);

    // tx_done exactly on the timeout cycle
    done_delay = 7;
    err_before = n_err;
    q0.push_back({1'b1, 8'h66});
    wait_idle("coincide", 60);
    exp_q = '{8'h66};
    check_order("coincide_order");
    check("coincide_no_err", 16'(n_err - err_before), 16'd0);

    // reset in WAIT, then a stale tx_done
    done_delay = -1;
    q0.push_back({1'b1, 8'h88});
    wait_dv("rst_mid_dv", 40);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    inject_done = 1'b1;
    dv_before = n_dv;
    tick(6);
    check("rstmid_busy",    16'(busy),           16'd0);
    check("rstmid_no_dv",   16'(n_dv - dv_before), 16'd0);
    check("rstmid_tx_byte", 16'(tx_byte),        16'h00);
    exp_q = '{8'h88};
    check_order("rstmid_order");
    done_delay = 2;
    q0.push_back({1'b1, 8'h91});
    q1.push_back({1'b1, 8'h92});
    wait_idle("rstmid_rr", 80);
    exp_q = '{8'h91, 8'h92};
    check_order("rstmid_rr_order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
